// File: rtl/symm_iter.sv
// symm_iter: iteration controller for symmetric decorrelation in the FastICA datapath.
// It holds the 4x4 unmixing matrix W and hands it to the SYMM_MUL3 stage, which
// returns H = 0.5*W*W'*W. It then forms W_next = 1.5*W - H and repeats until every
// element moves by no more than TOL LSBs, or until MAX_ITER iterations are done.
// Optional feature macro: SYMM_ITER_SAT_EN. When defined, each updated element is
// clamped to the DW-bit signed range. When undefined, it wraps (two's complement).
// Elements are packed row-major: element (r,c) is at bits [((r-1)*4+(c-1))*DW +: DW].

module symm_iter #(
    parameter int DW       = 26,
    parameter int MAX_ITER = 16,
    parameter int TOL      = 8
) (
    input  logic            clk_symm,
    input  logic            rstn_symm,
    input  logic            start,
    input  logic [16*DW-1:0] w_in,
    output logic [16*DW-1:0] w_mul,
    output logic            en_mul3,
    input  logic [16*DW-1:0] h_in,
    output logic [16*DW-1:0] w_out,
    output logic            busy,
    output logic            done,
    output logic            converged,
    output logic [7:0]      iter_cnt
);

    localparam int SW = DW + 2;
    localparam logic signed [SW-1:0] S_MAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] S_MIN = {3'b111, {(DW-1){1'b0}}};
    localparam logic [DW:0] TOL_V = TOL[DW:0];
    localparam logic [7:0]  MAX_V = MAX_ITER[7:0];

    typedef enum logic [1:0] {IDLE, MUL, UPD, DONE} state_t;

    state_t            state;
    logic [16*DW-1:0]  w_reg;
    logic [16*DW-1:0]  w_next;
    logic              all_within;
    logic              last_iter;

    logic signed [DW-1:0] w_e;
    logic signed [DW-1:0] w_half;
    logic signed [DW-1:0] h_e;
    logic signed [DW-1:0] r_e;
    logic signed [SW-1:0] s_e;
    logic signed [DW:0]   diff;
    logic [DW:0]          dabs;

    assign w_out = w_reg;
    assign w_mul = w_reg;
    assign last_iter = ((iter_cnt + 8'd1) == MAX_V);

    // Per-element update 1.5*W - H with wrap or clamp, and the all-elements tolerance test
    always_comb begin
        w_next     = '0;
        all_within = 1'b1;
        w_e        = '0;
        w_half     = '0;
        h_e        = '0;
        r_e        = '0;
        s_e        = '0;
        diff       = '0;
        dabs       = '0;
        for (int i = 0; i < 16; i++) begin
            w_e    = w_reg[i*DW +: DW];
            h_e    = h_in[i*DW +: DW];
            w_half = w_e >>> 1;
            s_e    = {{2{w_e[DW-1]}}, w_e} + {{2{w_half[DW-1]}}, w_half}
                   - {{2{h_e[DW-1]}}, h_e};
`ifdef SYMM_ITER_SAT_EN
            if (s_e > S_MAX) begin
                r_e = S_MAX[DW-1:0];
            end else if (s_e < S_MIN) begin
                r_e = S_MIN[DW-1:0];
            end else begin
                r_e = s_e[DW-1:0];
            end
`else
            r_e = s_e[DW-1:0];
`endif
            diff = {r_e[DW-1], r_e} - {w_e[DW-1], w_e};
            dabs = diff[DW] ? -diff : diff;
            if (dabs > TOL_V) begin
                all_within = 1'b0;
            end
            w_next[i*DW +: DW] = r_e;
        end
    end

    // Iteration FSM with registered handshake and status outputs
    always_ff @(posedge clk_symm or negedge rstn_symm) begin
        if (!rstn_symm) begin
            state     <= IDLE;
            w_reg     <= '0;
            en_mul3   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            converged <= 1'b0;
            iter_cnt  <= 8'd0;
        end else begin
            en_mul3 <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w_reg     <= w_in;
                        iter_cnt  <= 8'd0;
                        converged <= 1'b0;
                        busy      <= 1'b1;
                        en_mul3   <= 1'b1;
                        state     <= MUL;
                    end
                end
                MUL: begin
                    state <= UPD;
                end
                UPD: begin
                    w_reg    <= w_next;
                    iter_cnt <= iter_cnt + 8'd1;
                    if (all_within) begin
                        converged <= 1'b1;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (last_iter) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        en_mul3 <= 1'b1;
                        state   <= MUL;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
